// File: rtl/spu_issue_buffer_pkg.sv
// Shared definitions for the SPU issue buffer and decode.
// Contents:
//   pipe_t         - execution pipe a word belongs to (even / odd)
//   issue_state_t  - issue buffer FSM states
//   INSTR_BYTES    - byte distance between the two words of a fetch pair
//   pipe_of()      - instruction classification rule, shared with decode
package spu_issue_pkg;

  localparam int INSTR_BYTES = 4;

  typedef enum logic [0:0] {
    PIPE_EVEN = 1'b0,
    PIPE_ODD  = 1'b1
  } pipe_t;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    PAIR   = 2'd1,
    SINGLE = 2'd2
  } issue_state_t;

  // Odd pipe: opcode group 3'b001 or the lnop encoding; everything else is even.
  function automatic pipe_t pipe_of(input logic [31:0] instr);
    pipe_t p;
    if ((instr[31:29] == 3'b001) || (instr[31:21] == 11'h001)) begin
      p = PIPE_ODD;
    end else begin
      p = PIPE_EVEN;
    end
    return p;
  endfunction

endpackage

// File: rtl/spu_issue_buffer_if.sv
// Bundle of fetch-side and issue-side signals of the SPU issue buffer.
// master: fetch / control side (drives fetch pair, flush, stall; sees lanes)
// slave : the issue buffer (consumes fetch pair, drives fetch_ready and lanes)
interface spu_issue_buffer_if #(
  parameter int bitsize = 11,
  parameter int INSTR_W = 32
);

  logic               fetch_valid;
  logic [INSTR_W-1:0] fetch_output1;
  logic [INSTR_W-1:0] fetch_output2;
  logic [bitsize-1:0] fetch_pc;
  logic               flush;
  logic               stall;
  logic               fetch_ready;
  logic               even_valid;
  logic [INSTR_W-1:0] even_instr;
  logic [bitsize-1:0] even_pc;
  logic               odd_valid;
  logic [INSTR_W-1:0] odd_instr;
  logic [bitsize-1:0] odd_pc;
  logic               dual_issued;

  modport master (
    output fetch_valid, fetch_output1, fetch_output2, fetch_pc, flush, stall,
    input  fetch_ready, even_valid, even_instr, even_pc,
    input  odd_valid, odd_instr, odd_pc, dual_issued
  );

  modport slave (
    input  fetch_valid, fetch_output1, fetch_output2, fetch_pc, flush, stall,
    output fetch_ready, even_valid, even_instr, even_pc,
    output odd_valid, odd_instr, odd_pc, dual_issued
  );

endinterface

// File: rtl/spu_issue_buffer_router.sv
// Combinational lane router for the SPU issue buffer.
// Given the FSM state and the held pair, computes the next even/odd lane
// contents, their valids and the dual-issue flag. Lanes not launched this
// cycle keep their current instr/pc (hold_* inputs) with valid low.
// Ports:
//   state            current issue FSM state
//   slot0/slot1      held words, c0/c1 their pipe classes
//   pc0/pc1          addresses of slot0/slot1
//   hold_*           current lane instr/pc registers
//   aligned          pair can dual-issue (slot0 even, slot1 odd)
//   nxt_*            next lane register values
module spu_pipe_router
  import spu_issue_pkg::*;
#(
  parameter int bitsize = 11,
  parameter int INSTR_W = 32
) (
  input  issue_state_t       state,
  input  logic [INSTR_W-1:0] slot0,
  input  logic [INSTR_W-1:0] slot1,
  input  pipe_t              c0,
  input  pipe_t              c1,
  input  logic [bitsize-1:0] pc0,
  input  logic [bitsize-1:0] pc1,
  input  logic [INSTR_W-1:0] hold_even_instr,
  input  logic [bitsize-1:0] hold_even_pc,
  input  logic [INSTR_W-1:0] hold_odd_instr,
  input  logic [bitsize-1:0] hold_odd_pc,
  output logic               aligned,
  output logic               nxt_even_valid,
  output logic [INSTR_W-1:0] nxt_even_instr,
  output logic [bitsize-1:0] nxt_even_pc,
  output logic               nxt_odd_valid,
  output logic [INSTR_W-1:0] nxt_odd_instr,
  output logic [bitsize-1:0] nxt_odd_pc,
  output logic               nxt_dual
);

  assign aligned = (c0 == PIPE_EVEN) && (c1 == PIPE_ODD);

  // Route held words to lanes according to state and class.
  always_comb begin
    nxt_even_valid = 1'b0;
    nxt_even_instr = hold_even_instr;
    nxt_even_pc    = hold_even_pc;
    nxt_odd_valid  = 1'b0;
    nxt_odd_instr  = hold_odd_instr;
    nxt_odd_pc     = hold_odd_pc;
    nxt_dual       = 1'b0;
    case (state)
      PAIR: begin
        if (aligned) begin
          nxt_even_valid = 1'b1;
          nxt_even_instr = slot0;
          nxt_even_pc    = pc0;
          nxt_odd_valid  = 1'b1;
          nxt_odd_instr  = slot1;
          nxt_odd_pc     = pc1;
          nxt_dual       = 1'b1;
        end else if (c0 == PIPE_ODD) begin
          nxt_odd_valid  = 1'b1;
          nxt_odd_instr  = slot0;
          nxt_odd_pc     = pc0;
        end else begin
          nxt_even_valid = 1'b1;
          nxt_even_instr = slot0;
          nxt_even_pc    = pc0;
        end
      end
      SINGLE: begin
        if (c1 == PIPE_ODD) begin
          nxt_odd_valid  = 1'b1;
          nxt_odd_instr  = slot1;
          nxt_odd_pc     = pc1;
        end else begin
          nxt_even_valid = 1'b1;
          nxt_even_instr = slot1;
          nxt_even_pc    = pc1;
        end
      end
      EMPTY: begin
        nxt_dual = 1'b0;
      end
      default: begin
        nxt_dual = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/spu_issue_buffer.sv
// SPU issue buffer: holds one fetched instruction pair and issues it to the
// even and odd decode lanes, dual-issuing aligned pairs and splitting others
// over two cycles in program order.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset
//   bus    spu_issue_buffer_if.slave: fetch pair in, fetch_ready out,
//          flush/stall control in, registered even/odd lanes and dual_issued out
module spu_issue_buffer
  import spu_issue_pkg::*;
#(
  parameter int bitsize = 11,
  parameter int INSTR_W = 32
) (
  input logic                clk,
  input logic                reset,
  spu_issue_buffer_if.slave  bus
);

  issue_state_t       state_r;
  issue_state_t       state_nxt_s;
  logic [INSTR_W-1:0] slot0_r;
  logic [INSTR_W-1:0] slot1_r;
  logic [bitsize-1:0] pc0_r;
  pipe_t              c0_r;
  pipe_t              c1_r;
  logic [bitsize-1:0] pc1_s;

  logic               even_valid_r;
  logic [INSTR_W-1:0] even_instr_r;
  logic [bitsize-1:0] even_pc_r;
  logic               odd_valid_r;
  logic [INSTR_W-1:0] odd_instr_r;
  logic [bitsize-1:0] odd_pc_r;
  logic               dual_r;

  logic               aligned_s;
  logic               fetch_ready_s;
  logic               capture_s;
  logic               nxt_even_valid_s;
  logic [INSTR_W-1:0] nxt_even_instr_s;
  logic [bitsize-1:0] nxt_even_pc_s;
  logic               nxt_odd_valid_s;
  logic [INSTR_W-1:0] nxt_odd_instr_s;
  logic [bitsize-1:0] nxt_odd_pc_s;
  logic               nxt_dual_s;

  // Slot1 address wraps within the bitsize-wide address space.
  assign pc1_s = pc0_r + bitsize'(INSTR_BYTES);

  spu_pipe_router #(
    .bitsize (bitsize),
    .INSTR_W (INSTR_W)
  ) u_router (
    .state           (state_r),
    .slot0           (slot0_r),
    .slot1           (slot1_r),
    .c0              (c0_r),
    .c1              (c1_r),
    .pc0             (pc0_r),
    .pc1             (pc1_s),
    .hold_even_instr (even_instr_r),
    .hold_even_pc    (even_pc_r),
    .hold_odd_instr  (odd_instr_r),
    .hold_odd_pc     (odd_pc_r),
    .aligned         (aligned_s),
    .nxt_even_valid  (nxt_even_valid_s),
    .nxt_even_instr  (nxt_even_instr_s),
    .nxt_even_pc     (nxt_even_pc_s),
    .nxt_odd_valid   (nxt_odd_valid_s),
    .nxt_odd_instr   (nxt_odd_instr_s),
    .nxt_odd_pc      (nxt_odd_pc_s),
    .nxt_dual        (nxt_dual_s)
  );

  // Fetch may advance when the held pair drains this cycle; flush always
  // lets fetch advance so the redirected stream starts without a bubble.
  always_comb begin
    fetch_ready_s = 1'b0;
    if (bus.flush) begin
      fetch_ready_s = 1'b1;
    end else if (bus.stall) begin
      fetch_ready_s = 1'b0;
    end else begin
      case (state_r)
        EMPTY:   fetch_ready_s = 1'b1;
        PAIR:    fetch_ready_s = aligned_s;
        SINGLE:  fetch_ready_s = 1'b1;
        default: fetch_ready_s = 1'b0;
      endcase
    end
  end

  // The pair presented during a flush belongs to the discarded path.
  assign capture_s = bus.fetch_valid && fetch_ready_s && !bus.flush;

  // Next-state logic for the issue FSM (applied only on non-stalled edges).
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      EMPTY: begin
        if (capture_s) begin
          state_nxt_s = PAIR;
        end else begin
          state_nxt_s = EMPTY;
        end
      end
      PAIR: begin
        if (!aligned_s) begin
          state_nxt_s = SINGLE;
        end else if (capture_s) begin
          state_nxt_s = PAIR;
        end else begin
          state_nxt_s = EMPTY;
        end
      end
      SINGLE: begin
        if (capture_s) begin
          state_nxt_s = PAIR;
        end else begin
          state_nxt_s = EMPTY;
        end
      end
      default: begin
        state_nxt_s = EMPTY;
      end
    endcase
  end

  // FSM state and registered lane outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= EMPTY;
      even_valid_r <= 1'b0;
      even_instr_r <= '0;
      even_pc_r    <= '0;
      odd_valid_r  <= 1'b0;
      odd_instr_r  <= '0;
      odd_pc_r     <= '0;
      dual_r       <= 1'b0;
    end else if (bus.flush) begin
      state_r      <= EMPTY;
      even_valid_r <= 1'b0;
      odd_valid_r  <= 1'b0;
      dual_r       <= 1'b0;
    end else if (!bus.stall) begin
      state_r      <= state_nxt_s;
      even_valid_r <= nxt_even_valid_s;
      even_instr_r <= nxt_even_instr_s;
      even_pc_r    <= nxt_even_pc_s;
      odd_valid_r  <= nxt_odd_valid_s;
      odd_instr_r  <= nxt_odd_instr_s;
      odd_pc_r     <= nxt_odd_pc_s;
      dual_r       <= nxt_dual_s;
    end
  end

  // Holding register for the accepted fetch pair; validity is carried by state_r.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot0_r <= '0;
      slot1_r <= '0;
      pc0_r   <= '0;
      c0_r    <= PIPE_EVEN;
      c1_r    <= PIPE_EVEN;
    end else if (capture_s) begin
      slot0_r <= bus.fetch_output1;
      slot1_r <= bus.fetch_output2;
      pc0_r   <= bus.fetch_pc;
      c0_r    <= pipe_of(bus.fetch_output1);
      c1_r    <= pipe_of(bus.fetch_output2);
    end
  end

  assign bus.fetch_ready = fetch_ready_s;
  assign bus.even_valid  = even_valid_r;
  assign bus.even_instr  = even_instr_r;
  assign bus.even_pc     = even_pc_r;
  assign bus.odd_valid   = odd_valid_r;
  assign bus.odd_instr   = odd_instr_r;
  assign bus.odd_pc      = odd_pc_r;
  assign bus.dual_issued = dual_r;

endmodule

// File: tb/tb_spu_issue_buffer.sv
// Self-checking bench for spu_issue_buffer: directed scenarios followed by
// randomized traffic. A reference model tracks the number of issue groups
// still owed to decode, predicts fetch_ready, and queues the expected issue
// groups; a monitor compares every edge's lane outputs against that queue.
module tb_spu_issue_buffer;

  typedef struct packed {
    logic        ev;
    logic        ov;
    logic        dual;
    logic [31:0] ei;
    logic [31:0] oi;
    logic [10:0] ep;
    logic [10:0] op;
  } bundle_t;

  localparam int K_NORM  = 0;
  localparam int K_STALL = 1;
  localparam int K_FLUSH = 2;
  localparam int K_RESET = 3;
  localparam int K_SKIP  = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;

  spu_issue_buffer_if bus_if ();

  spu_issue_buffer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  int      tests = 0;
  int      fails = 0;
  bundle_t exp_q[$];
  int      pending = 0;
  int      edge_kind = K_SKIP;
  logic    exp_issue = 1'b0;
  bundle_t snap;
  int      mon_kind;
  bundle_t mon_b;
  bundle_t mon_cur;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bundle_t cur_out();
    bundle_t b;
    b.ev   = bus_if.even_valid;
    b.ov   = bus_if.odd_valid;
    b.dual = bus_if.dual_issued;
    b.ei   = bus_if.even_instr;
    b.oi   = bus_if.odd_instr;
    b.ep   = bus_if.even_pc;
    b.op   = bus_if.odd_pc;
    return b;
  endfunction

  function automatic bundle_t single_issue(input bit odd, input logic [31:0] w, input logic [10:0] pc);
    bundle_t b;
    b = '0;
    if (odd) begin
      b.ov = 1'b1;
      b.oi = w;
      b.op = pc;
    end else begin
      b.ev = 1'b1;
      b.ei = w;
      b.ep = pc;
    end
    return b;
  endfunction

  function automatic logic [31:0] gen_word(input bit odd);
    logic [31:0] w;
    if (odd) begin
      if ($urandom_range(0, 1) == 0) w = {3'b001, 29'($urandom)};
      else                           w = {11'h001, 21'($urandom)};
    end else begin
      w = $urandom;
      if (w[31:29] == 3'b001) w[31:29] = 3'b101;
      if (w[31:21] == 11'h001) w[22] = 1'b1;
    end
    return w;
  endfunction

  // One clock of stimulus: drive inputs, predict fetch_ready, update the model.
  task automatic step(input bit fv, input logic [31:0] w0, input bit c0odd,
                      input logic [31:0] w1, input bit c1odd, input logic [10:0] pc,
                      input bit fl, input bit st);
    bit          rdy_exp;
    logic [10:0] pc1;
    bundle_t     b;
    @(negedge clk);
    bus_if.fetch_valid   = fv;
    bus_if.fetch_output1 = w0;
    bus_if.fetch_output2 = w1;
    bus_if.fetch_pc      = pc;
    bus_if.flush         = fl;
    bus_if.stall         = st;
    #1;
    // At most one issue group owed means the last one leaves at this edge.
    rdy_exp = fl || (!st && (pending <= 1));
    chk("fetch_ready", 96'(bus_if.fetch_ready), 96'(rdy_exp));
    snap = cur_out();
    if (fl) begin
      exp_q.delete();
      pending   = 0;
      exp_issue = 1'b0;
      edge_kind = K_FLUSH;
    end else if (st) begin
      exp_issue = 1'b0;
      edge_kind = K_STALL;
    end else begin
      edge_kind = K_NORM;
      exp_issue = (pending > 0);
      if (pending > 0) pending--;
      if (fv && rdy_exp) begin
        pc1 = pc + 11'd4;
        if (!c0odd && c1odd) begin
          b      = '0;
          b.ev   = 1'b1;
          b.ei   = w0;
          b.ep   = pc;
          b.ov   = 1'b1;
          b.oi   = w1;
          b.op   = pc1;
          b.dual = 1'b1;
          exp_q.push_back(b);
          pending += 1;
        end else begin
          exp_q.push_back(single_issue(c0odd, w0, pc));
          exp_q.push_back(single_issue(c1odd, w1, pc1));
          pending += 2;
        end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 11'd0, 1'b0, 1'b0);
  endtask

  // Assert async reset between edges, check outputs clear at once, then release.
  task automatic do_reset();
    @(negedge clk);
    bus_if.fetch_valid   = 1'b0;
    bus_if.fetch_output1 = 32'd0;
    bus_if.fetch_output2 = 32'd0;
    bus_if.fetch_pc      = 11'd0;
    bus_if.flush         = 1'b0;
    bus_if.stall         = 1'b0;
    reset     = 1'b0;
    edge_kind = K_RESET;
    exp_q.delete();
    pending = 0;
    #1;
    chk("rst_even_valid", 96'(bus_if.even_valid), 96'd0);
    chk("rst_odd_valid", 96'(bus_if.odd_valid), 96'd0);
    chk("rst_dual", 96'(bus_if.dual_issued), 96'd0);
    chk("rst_even_instr", 96'(bus_if.even_instr), 96'd0);
    chk("rst_odd_instr", 96'(bus_if.odd_instr), 96'd0);
    chk("rst_even_pc", 96'(bus_if.even_pc), 96'd0);
    chk("rst_odd_pc", 96'(bus_if.odd_pc), 96'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset     = 1'b1;
    exp_issue = 1'b0;
    edge_kind = K_NORM;
    #1;
    chk("ready_after_reset", 96'(bus_if.fetch_ready), 96'd1);
  endtask

  // Monitor: after every edge compare outputs against what that edge must produce.
  always @(posedge clk) begin
    mon_kind = edge_kind;
    #1;
    mon_cur = cur_out();
    if (mon_kind == K_RESET) begin
      chk("reset_hold", 96'(mon_cur), 96'd0);
    end else if (mon_kind == K_STALL) begin
      chk("stall_frozen", 96'(mon_cur), 96'(snap));
    end else if (mon_kind == K_FLUSH) begin
      chk("flush_valids", 96'({mon_cur.ev, mon_cur.ov, mon_cur.dual}), 96'd0);
    end else if (mon_kind == K_NORM) begin
      chk("issue_present", 96'(mon_cur.ev || mon_cur.ov), 96'(exp_issue));
      if (mon_cur.ev || mon_cur.ov) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_issue: got %0h expected no issue", mon_cur);
        end else begin
          mon_b = exp_q.pop_front();
          chk("even_valid", 96'(mon_cur.ev), 96'(mon_b.ev));
          chk("odd_valid", 96'(mon_cur.ov), 96'(mon_b.ov));
          chk("dual_issued", 96'(mon_cur.dual), 96'(mon_b.dual));
          if (mon_b.ev) begin
            chk("even_instr", 96'(mon_cur.ei), 96'(mon_b.ei));
            chk("even_pc", 96'(mon_cur.ep), 96'(mon_b.ep));
          end
          if (mon_b.ov) begin
            chk("odd_instr", 96'(mon_cur.oi), 96'(mon_b.oi));
            chk("odd_pc", 96'(mon_cur.op), 96'(mon_b.op));
          end
        end
      end else begin
        chk("dual_idle", 96'(mon_cur.dual), 96'd0);
      end
    end
  end

  initial begin
    bit          fv, fl, st, c0, c1;
    logic [10:0] pc;
    bus_if.fetch_valid   = 1'b0;
    bus_if.fetch_output1 = 32'd0;
    bus_if.fetch_output2 = 32'd0;
    bus_if.fetch_pc      = 11'd0;
    bus_if.flush         = 1'b0;
    bus_if.stall         = 1'b0;

    do_reset();

    // Aligned pair: even nop + odd lnop dual-issue.
    step(1'b1, 32'h40200000, 1'b0, 32'h00200000, 1'b1, 11'h000, 1'b0, 1'b0);
    idle(2);

    // Both even: split over two cycles.
    step(1'b1, 32'h40200000, 1'b0, 32'h41000000, 1'b0, 11'h010, 1'b0, 1'b0);
    idle(3);

    // Reversed order (odd, even): split, odd first.
    step(1'b1, 32'h00200000, 1'b1, 32'h40200000, 1'b0, 11'h020, 1'b0, 1'b0);
    idle(3);

    // Stall three cycles while SINGLE, then slot1 issues.
    step(1'b1, 32'h40200000, 1'b0, 32'h41000000, 1'b0, 11'h030, 1'b0, 1'b0);
    idle(1);
    for (int i = 0; i < 3; i++) step(1'b1, 32'h20000000, 1'b1, 32'h20000001, 1'b1, 11'h038, 1'b0, 1'b1);
    idle(2);

    // Flush together with stall while PAIR; presented pair discarded.
    step(1'b1, 32'h40200000, 1'b0, 32'h00200000, 1'b1, 11'h040, 1'b0, 1'b0);
    step(1'b1, 32'h41000000, 1'b0, 32'h20000002, 1'b1, 11'h048, 1'b1, 1'b1);
    step(1'b1, 32'h40200000, 1'b0, 32'h00200000, 1'b1, 11'h050, 1'b0, 1'b0);
    idle(2);

    // Top-of-address-space split pair.
    step(1'b1, 32'h40200000, 1'b0, 32'h41000000, 1'b0, 11'h7F8, 1'b0, 1'b0);
    idle(3);

    // Async reset while SINGLE: pending slot1 never issues.
    step(1'b1, 32'h40200000, 1'b0, 32'h41000000, 1'b0, 11'h100, 1'b0, 1'b0);
    idle(1);
    do_reset();
    idle(3);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      fv = ($urandom_range(0, 99) < 70);
      fl = ($urandom_range(0, 99) < 4);
      st = ($urandom_range(0, 99) < 15);
      if ($urandom_range(0, 1) == 0) begin
        c0 = 1'b0;
        c1 = 1'b1;
      end else begin
        c0 = 1'($urandom_range(0, 1));
        c1 = 1'($urandom_range(0, 1));
      end
      pc = 11'($urandom_range(0, 255) * 8);
      step(fv, gen_word(c0), c0, gen_word(c1), c1, pc, fl, st);
    end

    idle(4);
    chk("queue_drained", 96'(exp_q.size()), 96'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/spu_issue_buffer.md
Name: spu_issue_buffer

Overview:
- Sits directly downstream of instruction fetch; consumes the fetched instruction pair (`fetch_output1`/`fetch_output2`) and its 11-bit address.
- Classifies each word as even-pipe or odd-pipe and issues through registered outputs to the even and odd decode lanes.
- Dual-issues when the pair is aligned (slot0 even, slot1 odd); otherwise splits the pair over two cycles and back-pressures fetch through `fetch_ready`, which drives fetch `PC_enable`.

Parameters:
- bitsize, 11, PC/address width (matches fetch).
- INSTR_W, 32, instruction word width.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- fetch_valid  input  1  fetch pair present this cycle.
- fetch_output1  input  32  slot0 word (address fetch_pc).
- fetch_output2  input  32  slot1 word (address fetch_pc+4).
- fetch_pc  input  bitsize  address of slot0; multiple of 8.
- flush  input  1  branch redirect; discard all held and issued state.
- stall  input  1  downstream hazard; freeze entire block.
- fetch_ready  output  1  block accepts a pair this cycle (to fetch PC_enable).
- even_valid  output  1  even lane holds an instruction.
- even_instr  output  32  even lane instruction.
- even_pc  output  bitsize  even lane instruction address.
- odd_valid  output  1  odd lane holds an instruction.
- odd_instr  output  32  odd lane instruction.
- odd_pc  output  bitsize  odd lane instruction address.
- dual_issued  output  1  pulse: last issue launched both lanes.

Behaviour:
- Priority: reset > flush > stall > normal operation.
- Reset (async, reset==0):
  - state=EMPTY; all valids, dual_issued, instr and pc outputs = 0.
  - fetch_ready=1 as soon as reset deasserts.
- Classification (package function), per word:
  - ODD iff instr[31:29]==3'b001 or instr[31:21]==11'h001 (lnop).
  - Otherwise EVEN.
- Holding register: slot0/slot1 words, slot0 pc, class bits.
  - slot1 pc = slot0 pc + 4, truncated to bitsize bits (wraps at 0x7FC → 0x000).
- FSM states: EMPTY, PAIR, SINGLE.
  - fetch_ready = !stall && (state==EMPTY || (state==PAIR && aligned) || state==SINGLE).
  - aligned = (c0==EVEN && c1==ODD).
- EMPTY:
  - fetch_valid && fetch_ready → capture pair, go to PAIR.
  - Otherwise stay; at the edge, output valids = 0.
- PAIR, aligned, not stalled:
  - Slot0 → even lane, slot1 → odd lane; both valids=1; dual_issued=1.
  - A new pair is captured in the same edge if fetch_valid → stay PAIR; else → EMPTY.
- PAIR, not aligned, not stalled:
  - Slot0 goes to the lane of its class; the other valid = 0; dual_issued=0.
  - Go to SINGLE; no capture (fetch_ready=0).
- SINGLE, not stalled:
  - Slot1 goes to the lane of its class; other valid = 0.
  - Capture the next pair if fetch_valid → PAIR; else → EMPTY.
- Both words same class: always split, slot0 first (program order preserved).
- Issue latency: pair captured at edge N.
  - Aligned: both lanes valid after edge N+1.
  - Split: slot0 after N+1, slot1 after N+2.
- stall=1:
  - All registers hold, including outputs and valids; fetch_ready=0.
  - fetch_valid is ignored.
- flush=1 (synchronous):
  - At the next edge: state=EMPTY; both valids=0; dual_issued=0; holding register invalidated.
  - fetch_ready=1 combinationally during the flush cycle; the pair presented in the flush cycle is discarded.
  - flush overrides stall.
- Reset mid-split (SINGLE): the pending slot1 is dropped; it is never issued after reset.
- Out-of-service lane outputs (instr/pc): hold their last value when valid=0; consumers qualify with valid.

Decomposition:
- Package spu_issue_pkg:
  - typedef enum pipe_t {PIPE_EVEN, PIPE_ODD};
  - typedef enum issue_state_t {EMPTY, PAIR, SINGLE};
  - function pipe_of(instr) implementing the classification rule (single source of truth, shared with decode).
  - constant INSTR_BYTES=4.
- One sub-module: spu_pipe_router.
  - Combinational; given state, slot words, class bits and pcs, produces next lane values, valids and dual flag.
  - The top holds the FSM and registers.

Test Plan:
- Aligned pair: reset, fetch_pc=0x000, w1=0x40200000 (even, nop), w2=0x00200000 (odd, lnop), fetch_valid=1.
  - After edge 2: even_instr=0x40200000, even_pc=0x000, odd_instr=0x00200000, odd_pc=0x004; both valid, dual_issued=1; fetch_ready stays 1.
- Both even at fetch_pc=0x010 → fetch_ready=0 for one cycle.
  - Cycle A: even lane pc=0x010, odd_valid=0.
  - Cycle B: even lane pc=0x014.
  - dual_issued=0 both cycles.
- Reversed order (odd, even) at 0x020 → odd lane pc=0x020 first, then even lane pc=0x024; never dual.
- Stall: assert stall for 3 cycles mid-SINGLE → outputs frozen and fetch_ready=0; on release, slot1 issues next edge.
- flush and stall together in PAIR state → next edge valids=0, state EMPTY; fetch_ready=1 in that cycle; next fetched pair issues normally.
- Wrap and async reset:
  - fetch_pc=0x7F8, split pair → slot1 pc=0x7FC.
  - Drop reset low mid-SINGLE → all outputs 0 immediately, no further issue.
